// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator.
//   state_t    : RUN (fetching normally) / FLUSH (cancelling in-flight fetch)
//   INST_BYTES : PC increment per launched fetch
//   ALIGN_MASK : low PC bits that must be zero for a legal fetch address
package pc_gen_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator feeding the instruction-fetch stage.
// Holds the next fetch address and advances it by INST_BYTES on every launch.
// Redirects and traps reload it and raise a one-cycle flush.
// Ports:
//   clk             : clock, rising edge
//   reset           : synchronous, active-low
//   fetch_busy      : fetch stage has a read outstanding
//   stall           : pipeline hazard stall
//   redirect_valid  : taken branch/jump this cycle
//   redirect_target : new PC for the redirect
//   trap_valid      : trap entry this cycle (wins over redirect)
//   trap_vector     : trap handler address, low two bits ignored
//   pc_addr         : next fetch address
//   flush           : cancel in-flight fetch / squash IF/ID
//   misalign        : one-cycle pulse for a misaligned redirect target
//   bad_addr        : target of the most recent misaligned redirect
//   fetch_count     : fetches launched since reset
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h8000_0000,
  parameter int unsigned            CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_busy,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  trap_valid,
  input  logic [ADDR_WIDTH-1:0] trap_vector,
  output logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  flush,
  output logic                  misalign,
  output logic [ADDR_WIDTH-1:0] bad_addr,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0] bad_q, bad_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic                  launch;
  logic [ADDR_WIDTH-1:0] trap_aligned;
  logic                  target_misaligned;

  assign launch            = (state_q == RUN) && !fetch_busy && !stall;
  assign trap_aligned      = trap_vector & ~ADDR_WIDTH'(ALIGN_MASK);
  assign target_misaligned = (redirect_target[1:0] & ALIGN_MASK) != 2'b00;

  always_comb begin
    state_d    = RUN;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    bad_d      = bad_q;
    // A launch coinciding with an event is still a real fetch and is counted.
    count_d    = launch ? count_q + CNT_WIDTH'(1) : count_q;

    if (trap_valid) begin
      pc_d    = trap_aligned;
      state_d = FLUSH;
    end else if (redirect_valid) begin
      state_d = FLUSH;
      if (target_misaligned) begin
        pc_d       = trap_aligned;
        bad_d      = redirect_target;
        misalign_d = 1'b1;
      end else begin
        pc_d = redirect_target;
      end
    end else if (launch) begin
      pc_d = pc_q + ADDR_WIDTH'(INST_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      bad_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      bad_q      <= bad_d;
      count_q    <= count_d;
    end
  end

  assign pc_addr     = pc_q;
  assign flush       = (state_q == FLUSH);
  assign misalign    = misalign_q;
  assign bad_addr    = bad_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_busy;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic [31:0] pc_addr;
  logic        flush;
  logic        misalign;
  logic [31:0] bad_addr;
  logic [31:0] fetch_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h8000_0000),
    .CNT_WIDTH (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_busy     (fetch_busy),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .pc_addr        (pc_addr),
    .flush          (flush),
    .misalign       (misalign),
    .bad_addr       (bad_addr),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        rst_n;
    logic        busy;
    logic        stl;
    logic        rv;
    logic [31:0] rt;
    logic        tv;
    logic [31:0] tvec;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_mis;
    logic [31:0] e_bad;
    logic [31:0] e_cnt;
  } vec_t;

  // Behavioural reference: spec rules applied with plain arithmetic.
  logic [31:0] m_pc, m_bad, m_cnt;
  logic        m_flushing, m_mis;

  function automatic void model_step(input logic rst_n, input logic busy, input logic stl,
                                     input logic rv, input logic [31:0] rt,
                                     input logic tv, input logic [31:0] tvec);
    logic        fetching;
    logic [31:0] handler;
    handler  = tvec - (tvec % 4);
    fetching = !m_flushing && !busy && !stl;
    if (!rst_n) begin
      m_pc = 32'h8000_0000; m_flushing = 0; m_mis = 0; m_bad = 0; m_cnt = 0;
      return;
    end
    if (fetching) m_cnt = m_cnt + 1;
    m_mis = 0;
    if (tv) begin
      m_pc = handler; m_flushing = 1;
    end else if (rv) begin
      m_flushing = 1;
      if (rt % 4 == 0) m_pc = rt;
      else begin
        m_pc = handler; m_bad = rt; m_mis = 1;
      end
    end else begin
      if (fetching) m_pc = m_pc + 4;
      m_flushing = 0;
    end
  endfunction

  task automatic apply(input string name, input logic rst_n, input logic busy, input logic stl,
                       input logic rv, input logic [31:0] rt,
                       input logic tv, input logic [31:0] tvec,
                       input logic [31:0] e_pc, input logic e_flush, input logic e_mis,
                       input logic [31:0] e_bad, input logic [31:0] e_cnt);
    reset = rst_n; fetch_busy = busy; stall = stl;
    redirect_valid = rv; redirect_target = rt; trap_valid = tv; trap_vector = tvec;
    @(posedge clk);
    #1;
    vectors++;
    if (pc_addr !== e_pc || flush !== e_flush || misalign !== e_mis ||
        bad_addr !== e_bad || fetch_count !== e_cnt) begin
      miscompares++;
      $display("FAIL %s: got pc=%h flush=%b mis=%b bad=%h cnt=%0d, expected pc=%h flush=%b mis=%b bad=%h cnt=%0d",
               name, pc_addr, flush, misalign, bad_addr, fetch_count,
               e_pc, e_flush, e_mis, e_bad, e_cnt);
    end
  endtask

  vec_t tbl[$];

  initial begin
    reset = 0; fetch_busy = 0; stall = 0; redirect_valid = 0; redirect_target = '0;
    trap_valid = 0; trap_vector = '0;

    //          rst busy stl rv rt            tv tvec          pc            fl mis bad           cnt
    tbl.push_back('{0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0000, 0, 0, 32'h0,         0});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0004, 0, 0, 32'h0,         1});
    tbl.push_back('{1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0004, 0, 0, 32'h0,         1});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0008, 0, 0, 32'h0,         2});
    tbl.push_back('{1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0008, 0, 0, 32'h0,         2});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_000C, 0, 0, 32'h0,         3});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1, 0, 1, 0, 32'h0,       0, 32'h0,         32'h8000_000C, 0, 0, 32'h0,         3});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0010, 0, 0, 32'h0,         4});
    // aligned redirect while busy
    tbl.push_back('{1, 1, 0, 1, 32'h8000_0100, 0, 32'h0,         32'h8000_0100, 1, 0, 32'h0,         4});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0100, 0, 0, 32'h0,         4});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0104, 0, 0, 32'h0,         5});
    // misaligned redirect goes to aligned trap vector
    tbl.push_back('{1, 1, 0, 1, 32'h8000_0102, 0, 32'h8000_0203, 32'h8000_0200, 1, 1, 32'h8000_0102, 5});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0200, 0, 0, 32'h8000_0102, 5});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0204, 0, 0, 32'h8000_0102, 6});
    // trap beats redirect, then redirect during FLUSH extends it
    tbl.push_back('{1, 1, 0, 1, 32'h8000_0100, 1, 32'h8000_0200, 32'h8000_0200, 1, 0, 32'h8000_0102, 6});
    tbl.push_back('{1, 0, 0, 1, 32'h8000_0300, 0, 32'h0,         32'h8000_0300, 1, 0, 32'h8000_0102, 6});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0300, 0, 0, 32'h8000_0102, 6});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0304, 0, 0, 32'h8000_0102, 7});
    // redirect coinciding with launch: launch counted, PC takes target
    tbl.push_back('{1, 0, 0, 1, 32'h8000_0400, 0, 32'h0,         32'h8000_0400, 1, 0, 32'h8000_0102, 8});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0400, 0, 0, 32'h8000_0102, 8});
    // wrap at the top of the address space
    tbl.push_back('{1, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 32'h8000_0102, 8});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC, 0, 0, 32'h8000_0102, 8});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 0, 32'h8000_0102, 9});
    // reset during FLUSH
    tbl.push_back('{1, 1, 0, 1, 32'h8000_0500, 0, 32'h0,         32'h8000_0500, 1, 0, 32'h8000_0102, 9});
    tbl.push_back('{0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0000, 0, 0, 32'h0,         0});
    // trap masks a misaligned redirect; trap vector low bits dropped
    tbl.push_back('{1, 1, 0, 1, 32'h8000_0001, 1, 32'h8000_0207, 32'h8000_0204, 1, 0, 32'h0,         0});
    tbl.push_back('{1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0204, 0, 0, 32'h0,         0});
    // stall does not block a redirect
    tbl.push_back('{1, 0, 1, 1, 32'h8000_0600, 0, 32'h0,         32'h8000_0600, 1, 0, 32'h0,         0});
    tbl.push_back('{1, 0, 1, 0, 32'h0,         0, 32'h0,         32'h8000_0600, 0, 0, 32'h0,         0});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h8000_0604, 0, 0, 32'h0,         1});

    foreach (tbl[i])
      apply($sformatf("table[%0d]", i), tbl[i].rst_n, tbl[i].busy, tbl[i].stl, tbl[i].rv, tbl[i].rt,
            tbl[i].tv, tbl[i].tvec, tbl[i].e_pc, tbl[i].e_flush, tbl[i].e_mis, tbl[i].e_bad, tbl[i].e_cnt);

    // Randomized phase: start model from a clean reset.
    m_pc = 0; m_bad = 0; m_cnt = 0; m_flushing = 0; m_mis = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_busy, r_stl, r_rv, r_tv;
      logic [31:0] r_rt, r_tvec;
      r_rst  = (n == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      r_busy = $urandom_range(0, 1) == 0;
      r_stl  = $urandom_range(0, 3) == 0;
      r_rv   = $urandom_range(0, 6) == 0;
      r_tv   = $urandom_range(0, 14) == 0;
      case ($urandom_range(0, 3))
        0:       r_rt = $urandom & ~32'd3;
        1:       r_rt = $urandom;
        2:       r_rt = 32'hFFFF_FFFC;
        default: r_rt = 32'h8000_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      endcase
      r_tvec = $urandom;
      model_step(r_rst, r_busy, r_stl, r_rv, r_rt, r_tv, r_tvec);
      apply($sformatf("random[%0d]", n), r_rst, r_busy, r_stl, r_rv, r_rt, r_tv, r_tvec,
            m_pc, m_flushing, m_mis, m_bad, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generator directly upstream of the instruction-fetch stage. Holds the next fetch address, presents it on `pc_addr`, and advances it by 4 each time the fetch stage accepts an address. Resolved branches/jumps and traps redirect the PC and raise a one-cycle `flush` that cancels any in-flight fetch and squashes the fetch-stage instruction. It also keeps a launched-fetch performance counter and reports misaligned redirect targets.

## Interface

- `RESET_PC`, 32'h8000_0000, PC value after reset.
- `ADDR_WIDTH`, 32, address width.
- `CNT_WIDTH`, 32, width of `fetch_count`.

- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `fetch_busy`  in  1  fetch stage has a read outstanding (its `stall_and_flush`).
- `stall`  in  1  pipeline hazard stall; same signal the fetch stage receives.
- `redirect_valid`  in  1  branch/jump resolved taken this cycle.
- `redirect_target`  in  ADDR_WIDTH  new PC for `redirect_valid`.
- `trap_valid`  in  1  trap/exception entry this cycle.
- `trap_vector`  in  ADDR_WIDTH  trap handler address; bits [1:0] ignored and treated as 0.
- `pc_addr`  out  ADDR_WIDTH  next fetch address, to fetch stage `PC_addr`.
- `flush`  out  1  cancel fetch / squash, to fetch stage `flush` and IF/ID.
- `misalign`  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0.
- `bad_addr`  out  ADDR_WIDTH  offending target of the last misalignment.
- `fetch_count`  out  CNT_WIDTH  number of fetches launched since reset.

## Operation

- States: RUN, FLUSH. `flush` = (state == FLUSH), decoded from the state register (glitch-free).
- Launch condition (mirrors the fetch stage): `launch` = RUN && !`fetch_busy` && !`stall`. At that edge, the fetch stage samples `pc_addr`.
- RUN, no event: if `launch`, `pc_addr` <= `pc_addr` + 4 (mod 2^ADDR_WIDTH, wraps FFFF_FFFC→0000_0000) and `fetch_count` += 1 (wraps). Otherwise hold.
- Event priority: `trap_valid` > `redirect_valid` > `launch`.
- On `trap_valid`: `pc_addr` <= {`trap_vector`[31:2], 2'b00}; state <= FLUSH.
- On `redirect_valid` (no trap): if `redirect_target`[1:0] == 0, `pc_addr` <= target. Otherwise `pc_addr` <= aligned `trap_vector`, `bad_addr` <= target, and `misalign` = 1 next cycle. In both cases state <= FLUSH.
- An event in the same cycle as `launch` still counts the launch in `fetch_count`; the PC takes the event target, not PC+4.
- FLUSH: lasts exactly one cycle. No launch and no PC advance. The next state is RUN.
  - An event during FLUSH reloads the PC per the rules above and stays in FLUSH, so the flush is extended by one cycle.
- `stall` never blocks a redirect or trap.

## Timing

- Reset (`reset`=0 at edge): `pc_addr`=RESET_PC, state=RUN, `flush`=0, `misalign`=0, `bad_addr`=0, `fetch_count`=0.
  - The first launch of RESET_PC occurs at the first edge with `reset`=1, `stall`=0, `fetch_busy`=0.
  - Reset mid-FLUSH or mid-fetch returns to RUN immediately.
- Redirect latency: event sampled at edge N. `flush`=1 during cycle N..N+1. The fetch stage cancels at edge N+1. The target is launched at edge N+2 at the earliest.
- `misalign` is high for exactly the FLUSH cycle caused by that redirect.
- Back-to-back launches are limited by `fetch_busy`. A single-cycle-ack memory gives one launch per 2 cycles.
- All outputs are registered or decoded from registers. There are no combinational input→output paths.

## Structure

- `pc_gen_pkg`: `state_t` enum {RUN, FLUSH}, `INST_BYTES` = 4, `ALIGN_MASK` = 2'b11.
- Single flat module with no sub-module. The perf counter is inline.

## Test plan

- Reset, then `stall`=0 and `fetch_busy` modelled as 1 cycle after each launch → launched addresses 8000_0000, 8000_0004, 8000_0008; `fetch_count`=3 after three launches.
- `stall`=1 for 5 cycles while idle → `pc_addr` holds, `fetch_count` unchanged; release → next launch uses the held address.
- `redirect_valid` with target 8000_0100 while `fetch_busy`=1 → `flush`=1 for one cycle; next launch address is 8000_0100; `misalign`=0.
- `redirect_valid` with target 8000_0102 and `trap_vector`=8000_0203 → `pc_addr`=8000_0200, `misalign` pulses 1 cycle, `bad_addr`=8000_0102.
- `trap_valid` (vector 8000_0200) and `redirect_valid` (8000_0100) in the same cycle, then a second redirect (8000_0300) during FLUSH → `flush` high 2 cycles; final launch address 8000_0300.
- PC preloaded near top (redirect to FFFF_FFFC) then one launch → `pc_addr`=0000_0000. Assert `reset`=0 during FLUSH → next cycle `flush`=0 and `pc_addr`=8000_0000.
